// File: rtl/seqn_gen.sv
// seqn_gen: framed serial pattern generator.
// A word accepted through load/ready is sent on dout one bit per clock:
// the PREAMBLE pattern (bit PRE_LEN-1 first), then the word MSB-first,
// then an optional idle gap of GAP_CYC cycles before ready returns.
// Optional feature macro: SEQN_GEN_PARITY_EN appends one even-parity bit
// (XOR of the accepted word) after the data bits; last moves onto that bit.
// All outputs come straight from flops; the next output values are decoded
// from the next FSM state so that each bit appears on the edge that enters it.
module seqn_gen #(
  parameter int          DATA_W   = 8,
  parameter int          PRE_LEN  = 4,
  parameter logic [15:0] PREAMBLE = 16'h000A,
  parameter int          GAP_CYC  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              last,
  output logic              busy
);

  // Counter must hold the largest per-state count without wrapping.
  localparam int MAX_PD = (PRE_LEN > DATA_W) ? PRE_LEN : DATA_W;
  localparam int MAX_C  = (MAX_PD > GAP_CYC) ? MAX_PD : GAP_CYC;
  localparam int CNT_W  = $clog2(MAX_C) + 1;

  localparam logic [CNT_W-1:0] PRE_END  = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_END = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYC - 1);
  localparam logic [15:0]      PRE_PAT  = PREAMBLE;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_DATA = 3'd2,
`ifdef SEQN_GEN_PARITY_EN
    ST_PAR  = 3'd4,
`endif
    ST_GAP  = 3'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_sreg, w_sreg_nxt;
  logic [3:0]        w_pre_idx;
  logic              w_dout_nxt, w_valid_nxt, w_last_nxt;
  logic              r_dout, r_valid, r_last, r_busy, r_ready;

`ifdef SEQN_GEN_PARITY_EN
  logic r_par, w_par_nxt;

  // Even-parity bit: XOR of all bits of the word.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    even_parity = ^d;
  endfunction
`endif

  // Next-state, counter, shift-register and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sreg_nxt  = r_sreg;
`ifdef SEQN_GEN_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_state_nxt = ST_PRE;
          w_cnt_nxt   = '0;
          w_sreg_nxt  = data_in;
`ifdef SEQN_GEN_PARITY_EN
          w_par_nxt   = even_parity(data_in);
`endif
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (r_cnt == PRE_END) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (r_cnt == DATA_END) begin
          w_cnt_nxt = '0;
`ifdef SEQN_GEN_PARITY_EN
          w_state_nxt = ST_PAR;
`else
          if (GAP_CYC != 0) begin
            w_state_nxt = ST_GAP;
          end else begin
            w_state_nxt = ST_IDLE;
          end
`endif
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`ifdef SEQN_GEN_PARITY_EN
      ST_PAR: begin
        w_cnt_nxt = '0;
        if (GAP_CYC != 0) begin
          w_state_nxt = ST_GAP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      ST_GAP: begin
        if (r_cnt == GAP_END) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // The MSB goes out on the edge entering each data bit; shift on that edge.
    if (w_state_nxt == ST_DATA) begin
      w_sreg_nxt = r_sreg << 1;
    end else begin
      w_sreg_nxt = w_sreg_nxt;
    end

    w_pre_idx   = 4'(PRE_LEN - 1) - 4'(w_cnt_nxt);
    w_dout_nxt  = 1'b0;
    w_valid_nxt = 1'b0;
    w_last_nxt  = 1'b0;
    case (w_state_nxt)
      ST_PRE: begin
        w_dout_nxt  = PRE_PAT[w_pre_idx];
        w_valid_nxt = 1'b1;
      end
      ST_DATA: begin
        w_dout_nxt  = r_sreg[DATA_W-1];
        w_valid_nxt = 1'b1;
`ifdef SEQN_GEN_PARITY_EN
        w_last_nxt  = 1'b0;
`else
        w_last_nxt  = (w_cnt_nxt == DATA_END);
`endif
      end
`ifdef SEQN_GEN_PARITY_EN
      ST_PAR: begin
        w_dout_nxt  = r_par;
        w_valid_nxt = 1'b1;
        w_last_nxt  = 1'b1;
      end
`endif
      default: begin
        w_dout_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
      end
    endcase
  end

  // FSM state, bit counter and shift-register flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sreg  <= '0;
`ifdef SEQN_GEN_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sreg  <= w_sreg_nxt;
`ifdef SEQN_GEN_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  // Output flops, loaded with the values belonging to the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_dout  <= w_dout_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign last       = r_last;
  assign busy       = r_busy;
  assign ready      = r_ready;

endmodule

// File: tb/tb_seqn_gen.sv
// Directed bench for seqn_gen: u_dut0 uses GAP_CYC=1, u_dut1 uses GAP_CYC=0.
// Expected frames are hand-computed constants; the parity build appends
// the even-parity bit to every frame.
module tb_seqn_gen;

`ifdef SEQN_GEN_PARITY_EN
  localparam int          FL    = 13;
  localparam logic [31:0] E_C5  = 32'h0000158A;
  localparam logic [31:0] E_07  = 32'h0000140F;
  localparam logic [31:0] E_00  = 32'h00001400;
  localparam logic [31:0] E_81  = 32'h00001502;
  localparam logic [31:0] E_3C  = 32'h00001478;
  localparam logic [31:0] E_A5  = 32'h0000154A;
`else
  localparam int          FL    = 12;
  localparam logic [31:0] E_C5  = 32'h00000AC5;
  localparam logic [31:0] E_07  = 32'h00000A07;
  localparam logic [31:0] E_00  = 32'h00000A00;
  localparam logic [31:0] E_81  = 32'h00000A81;
  localparam logic [31:0] E_3C  = 32'h00000A3C;
  localparam logic [31:0] E_A5  = 32'h00000AA5;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data0, data1;
  logic       load0, load1;
  logic       ready0, dout0, valid0, last0, busy0;
  logic       ready1, dout1, valid1, last1, busy1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seqn_gen #(.DATA_W(8), .PRE_LEN(4), .PREAMBLE(16'h000A), .GAP_CYC(1)) u_dut0 (
    .clk(clk), .reset(reset), .data_in(data0), .load(load0), .ready(ready0),
    .dout(dout0), .dout_valid(valid0), .last(last0), .busy(busy0)
  );

  seqn_gen #(.DATA_W(8), .PRE_LEN(4), .PREAMBLE(16'h000A), .GAP_CYC(0)) u_dut1 (
    .clk(clk), .reset(reset), .data_in(data1), .load(load1), .ready(ready1),
    .dout(dout1), .dout_valid(valid1), .last(last1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one load pulse to u_dut0; returns at the negedge of the first frame bit.
  task automatic send0(input logic [7:0] d);
    @(negedge clk);
    data0 = d;
    load0 = 1'b1;
    @(negedge clk);
    load0 = 1'b0;
  endtask

  // Sample u_dut0 over a fixed window; optionally hold load=1 (data FF) on cycles ld_from..ld_to.
  task automatic grab0(input int ld_from, input int ld_to, output logic [31:0] word,
                       output int nv, output int lpos, output int lcnt, output int rdy_at);
    word = 32'h0; nv = 0; lpos = 0; lcnt = 0; rdy_at = 0;
    for (int c = 1; c <= FL + 4; c++) begin
      if (c > 1) @(negedge clk);
      if (valid0) begin
        word = {word[30:0], dout0};
        nv++;
      end
      if (last0) begin
        lcnt++;
        lpos = c;
      end
      if (ready0 && rdy_at == 0) rdy_at = c;
      if (c >= ld_from && c <= ld_to) begin
        load0 = 1'b1;
        data0 = 8'hFF;
      end else begin
        load0 = 1'b0;
      end
    end
  endtask

  initial begin
    logic [31:0] w, w1, w2;
    int nv, lpos, lcnt, rdy, l1, f2, lc;

    reset = 1'b0; load0 = 1'b0; load1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_dout",  {31'd0, dout0},  32'd0);
    check("rst_valid", {31'd0, valid0}, 32'd0);
    check("rst_last",  {31'd0, last0},  32'd0);
    check("rst_busy",  {31'd0, busy0},  32'd0);
    check("rst_ready", {31'd0, ready0}, 32'd1);
    reset = 1'b1;

    // Single frame, 8'hC5.
    send0(8'hC5);
    grab0(0, 0, w, nv, lpos, lcnt, rdy);
    check("c5_word",  w, E_C5);
    check("c5_nvalid", nv, FL);
    check("c5_lastpos", lpos, FL);
    check("c5_lastcnt", lcnt, 1);
    check("c5_ready_rise", rdy, FL + 2);

    // Parity-sensitive word 8'h07.
    send0(8'h07);
    grab0(0, 0, w, nv, lpos, lcnt, rdy);
    check("07_word", w, E_07);
    check("07_lastpos", lpos, FL);

    // load while busy is ignored.
    send0(8'h00);
    grab0(6, 8, w, nv, lpos, lcnt, rdy);
    check("busyld_word", w, E_00);
    check("busyld_nvalid", nv, FL);
    check("busyld_lastcnt", lcnt, 1);
    check("busyld_idle_valid", {31'd0, valid0}, 32'd0);

    // Reset mid-frame at the 6th bit.
    send0(8'h5A);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_dout",  {31'd0, dout0},  32'd0);
    check("midrst_valid", {31'd0, valid0}, 32'd0);
    check("midrst_last",  {31'd0, last0},  32'd0);
    check("midrst_busy",  {31'd0, busy0},  32'd0);
    check("midrst_ready", {31'd0, ready0}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    send0(8'h81);
    grab0(0, 0, w, nv, lpos, lcnt, rdy);
    check("81_word", w, E_81);
    check("81_nvalid", nv, FL);
    check("81_lastpos", lpos, FL);

    // Back-to-back on the GAP_CYC=0 instance with load held high.
    @(negedge clk);
    data1 = 8'h3C;
    load1 = 1'b1;
    w1 = 32'h0; w2 = 32'h0; l1 = 0; f2 = 0; lc = 0;
    for (int c = 1; c <= 2 * FL + 4; c++) begin
      @(negedge clk);
      if (valid1) begin
        if (lc == 0) w1 = {w1[30:0], dout1};
        else         w2 = {w2[30:0], dout1};
        if (lc == 1 && f2 == 0) f2 = c;
      end
      if (last1) begin
        lc++;
        if (lc == 1) l1 = c;
      end
      if (c == 2)      data1 = 8'h99;
      if (c == FL + 1) data1 = 8'hA5;
      if (c == FL + 2) load1 = 1'b0;
    end
    check("b2b_word1", w1, E_3C);
    check("b2b_word2", w2, E_A5);
    check("b2b_gap", f2 - l1, 2);
    check("b2b_lastcnt", lc, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
